mac_operand_streamer: RTL and testbench

// - Source end of the MAC operand streams. Stores two operand vectors (A, B) written by a host port.
// - On start, streams them out as two independent valid/ready/last channels into the MAC slave ports.
// - Then accepts the single MAC result beat (data plus overflow/underflow flags) and holds it for the host.
// - Sits between the host/config logic and the mac block; one vector-pair dot product per start.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_stream_channel.sv | 47 ++++
 rtl/mac_operand_streamer.sv | 173 +++++++++++++++++
 tb/tb_mac_operand_streamer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC operand streamer and the MAC datapath.
package mac_pkg;

  localparam int MAC_DATA_W_A = 16;
  localparam int MAC_DATA_W_B = 16;
  localparam int MAC_RES_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES,
    DONE
  } streamer_state_t;

endpackage

// File: rtl/mac_stream_channel.sv
// One operand channel: host-written buffer, beat index and valid/last generation.
// Data and last are pure functions of the index, so they hold while a beat stalls.
module mac_stream_channel
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W_A,
  parameter int DEPTH  = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       load,
  input  logic                       run,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       ready,
  output logic                       valid,
  output logic [DATA_W-1:0]          data,
  output logic                       last,
  output logic                       finished
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LW-1:0]     idx;

  // Host write into the operand buffer (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Beat index: cleared when a run is accepted, advanced on every transfer
  always_ff @(posedge clk) begin
    if (reset)              idx <= '0;
    else if (load)          idx <= '0;
    else if (valid && ready) idx <= idx + LW'(1);
  end

  assign valid    = run && (idx < len);
  assign data     = mem[idx[AW-1:0]];
  assign last     = valid && (idx == len - LW'(1));
  assign finished = (idx == len);

endmodule

// File: rtl/mac_operand_streamer.sv
// Source end of the MAC operand streams: run FSM, result wait with timeout,
// result capture, and two independent operand channels.
module mac_operand_streamer
  import mac_pkg::*;
#(
  parameter int DATA_W_A = MAC_DATA_W_A,
  parameter int DATA_W_B = MAC_DATA_W_B,
  parameter int RES_W    = MAC_RES_W,
  parameter int DEPTH    = 128,
  parameter int TIMEOUT  = 1024
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              wr_en,
  input  logic                                              wr_sel,
  input  logic [$clog2(DEPTH)-1:0]                          wr_addr,
  input  logic [((DATA_W_A > DATA_W_B) ? DATA_W_A : DATA_W_B)-1:0] wr_data,
  input  logic [$clog2(DEPTH):0]                            len,
  input  logic                                              start,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              err,
  output logic                                              m_valid_a,
  input  logic                                              m_ready_a,
  output logic                                              m_last_a,
  output logic [DATA_W_A-1:0]                               m_data_a,
  output logic                                              m_valid_b,
  input  logic                                              m_ready_b,
  output logic                                              m_last_b,
  output logic [DATA_W_B-1:0]                               m_data_b,
  input  logic                                              s_res_valid,
  output logic                                              s_res_ready,
  input  logic [RES_W-1:0]                                  s_res_data,
  input  logic                                              s_res_ovf,
  input  logic                                              s_res_unf,
  output logic [RES_W-1:0]                                  result,
  output logic                                              result_ovf,
  output logic                                              result_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  streamer_state_t state, state_nxt;
  logic [LW-1:0]   len_q;
  logic [TW-1:0]   tcnt;
  logic            to_err;
  logic            zero_pulse;
  logic            accept, zero_req, capture;
  logic            run;
  logic            fin_a, fin_b;

  // Lengths above the buffer size are clamped to the buffer size
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l > LW'(DEPTH)) return LW'(DEPTH);
    return l;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    zero_req  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            zero_req = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        if (fin_a && fin_b) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (s_res_valid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Run length latch, timeout counter and error bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      tcnt       <= '0;
      to_err     <= 1'b0;
      zero_pulse <= 1'b0;
    end else begin
      zero_pulse <= zero_req;
      if (accept) len_q <= clamp_len(len);
      if (state == WAIT_RES) tcnt <= tcnt + TW'(1);
      else                   tcnt <= '0;
      if (accept) to_err <= 1'b0;
      else if (state == WAIT_RES && state_nxt == DONE) to_err <= !capture;
    end
  end

  // Result capture, held until the next accepted result
  always_ff @(posedge clk) begin
    if (reset) begin
      result     <= '0;
      result_ovf <= 1'b0;
      result_unf <= 1'b0;
    end else if (capture) begin
      result     <= s_res_data;
      result_ovf <= s_res_ovf;
      result_unf <= s_res_unf;
    end
  end

  assign run         = (state == STREAM);
  assign busy        = (state == STREAM) || (state == WAIT_RES);
  assign s_res_ready = (state == WAIT_RES);
  assign done        = (state == DONE) || zero_pulse;
  assign err         = ((state == DONE) && to_err) || zero_pulse;

  mac_stream_channel #(
    .DATA_W (DATA_W_A),
    .DEPTH  (DEPTH)
  ) u_chan_a (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en && !wr_sel && (state == IDLE)),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data[DATA_W_A-1:0]),
    .load     (accept),
    .run      (run),
    .len      (len_q),
    .ready    (m_ready_a),
    .valid    (m_valid_a),
    .data     (m_data_a),
    .last     (m_last_a),
    .finished (fin_a)
  );

  mac_stream_channel #(
    .DATA_W (DATA_W_B),
    .DEPTH  (DEPTH)
  ) u_chan_b (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en && wr_sel && (state == IDLE)),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data[DATA_W_B-1:0]),
    .load     (accept),
    .run      (run),
    .len      (len_q),
    .ready    (m_ready_b),
    .valid    (m_valid_b),
    .data     (m_data_b),
    .last     (m_last_b),
    .finished (fin_b)
  );

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Directed bench for mac_operand_streamer: streaming, stalls, result capture,
// timeout, zero length, ignored restart and reset mid-run.
module tb_mac_operand_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        wr_sel;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  len;
  logic        start;
  logic        busy, done, err;
  logic        m_valid_a, m_ready_a, m_last_a;
  logic [15:0] m_data_a;
  logic        m_valid_b, m_ready_b, m_last_b;
  logic [15:0] m_data_b;
  logic        s_res_valid, s_res_ready;
  logic [31:0] s_res_data;
  logic        s_res_ovf, s_res_unf;
  logic [31:0] result;
  logic        result_ovf, result_unf;

  int checks = 0;
  int errors = 0;

  logic [15:0] ea [8];
  logic [15:0] eb [8];

  int na = 0, nb = 0, rdy_na = 0, rdy_nb = 0;
  int ba = 0, bb = 0;
  logic [15:0] cap_da [256];
  logic [15:0] cap_db [256];
  logic        cap_la [256];
  logic        cap_lb [256];
  logic        pva = 1'b0, pra = 1'b0, pla = 1'b0;
  logic        pvb = 1'b0, prb = 1'b0, plb = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [15:0] pda = '0, pdb = '0;

  mac_operand_streamer #(
    .DATA_W_A (16),
    .DATA_W_B (16),
    .RES_W    (32),
    .DEPTH    (128),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .len         (len),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .m_valid_a   (m_valid_a),
    .m_ready_a   (m_ready_a),
    .m_last_a    (m_last_a),
    .m_data_a    (m_data_a),
    .m_valid_b   (m_valid_b),
    .m_ready_b   (m_ready_b),
    .m_last_b    (m_last_b),
    .m_data_b    (m_data_b),
    .s_res_valid (s_res_valid),
    .s_res_ready (s_res_ready),
    .s_res_data  (s_res_data),
    .s_res_ovf   (s_res_ovf),
    .s_res_unf   (s_res_unf),
    .result      (result),
    .result_ovf  (result_ovf),
    .result_unf  (result_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat capture, stall-stability check and WAIT_RES entry snapshot
  always @(negedge clk) begin
    if (pva && !pra) chk("stable_a", 64'({m_valid_a, m_last_a, m_data_a}), 64'({1'b1, pla, pda}));
    if (pvb && !prb) chk("stable_b", 64'({m_valid_b, m_last_b, m_data_b}), 64'({1'b1, plb, pdb}));
    if (m_valid_a && m_ready_a && na < 256) begin
      cap_da[na] = m_data_a; cap_la[na] = m_last_a; na++;
    end
    if (m_valid_b && m_ready_b && nb < 256) begin
      cap_db[nb] = m_data_b; cap_lb[nb] = m_last_b; nb++;
    end
    if (s_res_ready && !prev_rdy) begin
      rdy_na = na; rdy_nb = nb;
    end
    pva = m_valid_a; pra = m_ready_a; pla = m_last_a; pda = m_data_a;
    pvb = m_valid_b; prb = m_ready_b; plb = m_last_b; pdb = m_data_b;
    prev_rdy = s_res_ready;
  end

  task automatic write_op(input logic sel, input logic [6:0] addr, input logic [15:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Start a run and step cycle by cycle until done; k counts cycles after the start cycle
  task automatic run_vec(input logic [7:0] l, input int rmode, input int res_delay,
                         input logic [31:0] rdata, input logic rovf, input logic runf,
                         input int restart_at, output int done_k, output logic err_k,
                         output logic busy_seen);
    int wcnt;
    ba = na; bb = nb;
    wcnt = 0; done_k = -1; err_k = 1'b0; busy_seen = 1'b0;
    s_res_data = rdata; s_res_ovf = rovf; s_res_unf = runf;
    len = l; start = 1'b1;
    m_ready_a = 1'b1; m_ready_b = 1'b1;
    s_res_valid = (res_delay == 0);
    @(posedge clk); #1;
    for (int k = 1; k <= 60; k++) begin
      start       = (k == restart_at);
      m_ready_a   = (rmode == 1) ? (k % 2 == 1) : 1'b1;
      m_ready_b   = (rmode == 1) ? (k > 5) : 1'b1;
      s_res_valid = (res_delay >= 0) && (wcnt >= res_delay);
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (s_res_ready) wcnt++;
      if (done) begin
        done_k = k;
        err_k  = err;
        chk("busy_at_done", 64'(busy), 64'(0));
        break;
      end
      @(posedge clk); #1;
    end
    if (done_k < 0) chk("done_seen", 64'(0), 64'(1));
    @(posedge clk); #1;
    start = 1'b0; s_res_valid = 1'b0; m_ready_a = 1'b1; m_ready_b = 1'b1;
  endtask

  task automatic check_beats(input int l);
    chk("beats_a", 64'(na - ba), 64'(l));
    chk("beats_b", 64'(nb - bb), 64'(l));
    for (int i = 0; i < l; i++) begin
      chk("data_a", 64'(cap_da[ba + i]), 64'(ea[i]));
      chk("data_b", 64'(cap_db[bb + i]), 64'(eb[i]));
      chk("last_a", 64'(cap_la[ba + i]), 64'(i == l - 1));
      chk("last_b", 64'(cap_lb[bb + i]), 64'(i == l - 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dk;
    logic        ek, bs;
    int          cnt;

    ea[0] = 16'h0100; ea[1] = 16'h0200; ea[2] = 16'hFE80;
    eb[0] = 16'h0200; eb[1] = 16'h0080; eb[2] = 16'h0200;
    for (int i = 3; i < 8; i++) begin
      ea[i] = 16'h1000 + 16'(i);
      eb[i] = 16'h2000 + 16'(i);
    end

    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; start = 1'b0; m_ready_a = 1'b1; m_ready_b = 1'b1;
    s_res_valid = 1'b0; s_res_data = '0; s_res_ovf = 1'b0; s_res_unf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    64'(busy),        64'(0));
    chk("rst_done",    64'(done),        64'(0));
    chk("rst_err",     64'(err),         64'(0));
    chk("rst_valid_a", 64'(m_valid_a),   64'(0));
    chk("rst_valid_b", 64'(m_valid_b),   64'(0));
    chk("rst_last",    64'({m_last_a, m_last_b}), 64'(0));
    chk("rst_ready",   64'(s_res_ready), 64'(0));
    chk("rst_result",  64'({result, result_ovf, result_unf}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      write_op(1'b0, 7'(i), ea[i]);
      write_op(1'b1, 7'(i), eb[i]);
    end

    // Basic run, ready tied high, result already waiting during STREAM
    run_vec(8'd3, 0, 0, 32'h1234_5678, 1'b0, 1'b1, -1, dk, ek, bs);
    chk("t1_done_k", 64'(dk), 64'(6));
    chk("t1_err",    64'(ek), 64'(0));
    check_beats(3);
    chk("t1_rdy_after_a", 64'(rdy_na - ba), 64'(3));
    chk("t1_result", 64'(result), 64'(32'h1234_5678));
    chk("t1_flags",  64'({result_ovf, result_unf}), 64'(2'b01));

    // A toggling ready, B stalled five cycles
    run_vec(8'd3, 1, 0, 32'hCAFE_0001, 1'b0, 1'b0, -1, dk, ek, bs);
    chk("t2_done_k", 64'(dk), 64'(11));
    check_beats(3);
    chk("t2_rdy_after_a", 64'(rdy_na - ba), 64'(3));
    chk("t2_rdy_after_b", 64'(rdy_nb - bb), 64'(3));
    chk("t2_result", 64'(result), 64'(32'hCAFE_0001));

    // Result arrives four cycles into WAIT_RES with overflow
    run_vec(8'd3, 0, 4, 32'h0001_0000, 1'b1, 1'b0, -1, dk, ek, bs);
    chk("t3_done_k", 64'(dk), 64'(10));
    chk("t3_err",    64'(ek), 64'(0));
    chk("t3_result", 64'(result), 64'(32'h0001_0000));
    chk("t3_flags",  64'({result_ovf, result_unf}), 64'(2'b10));

    // No result: timeout 16 cycles after entering WAIT_RES
    run_vec(8'd3, 0, -1, 32'hDEAD_BEEF, 1'b0, 1'b1, -1, dk, ek, bs);
    chk("t4_done_k", 64'(dk), 64'(21));
    chk("t4_err",    64'(ek), 64'(1));
    chk("t4_result", 64'(result), 64'(32'h0001_0000));
    chk("t4_flags",  64'({result_ovf, result_unf}), 64'(2'b10));

    // Zero length
    run_vec(8'd0, 0, 0, 32'h0, 1'b0, 1'b0, -1, dk, ek, bs);
    chk("t5_done_k", 64'(dk), 64'(1));
    chk("t5_err",    64'(ek), 64'(1));
    chk("t5_busy",   64'(bs), 64'(0));
    chk("t5_beats",  64'(na - ba), 64'(0));

    // Start pulsed again during STREAM is ignored
    run_vec(8'd3, 0, 0, 32'h0000_0077, 1'b0, 1'b0, 2, dk, ek, bs);
    chk("t6_done_k", 64'(dk), 64'(6));
    chk("t6_err",    64'(ek), 64'(0));
    check_beats(3);

    // Reset asserted at beat 2 of a length-8 run
    ba = na; bb = nb;
    len = 8'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t7_valid_a", 64'(m_valid_a), 64'(0));
    chk("t7_valid_b", 64'(m_valid_b), 64'(0));
    chk("t7_busy",    64'(busy),      64'(0));
    chk("t7_done",    64'(done),      64'(0));
    chk("t7_beats_a", 64'(na - ba),   64'(2));
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("t7_quiet", 64'(cnt), 64'(0));
    @(posedge clk); #1;

    // Following length-8 run streams the full vectors
    run_vec(8'd8, 0, 0, 32'h8888_0008, 1'b0, 1'b0, -1, dk, ek, bs);
    chk("t8_done_k", 64'(dk), 64'(11));
    chk("t8_err",    64'(ek), 64'(0));
    check_beats(8);
    chk("t8_result", 64'(result), 64'(32'h8888_0008));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
